triangle_setup: RTL and testbench

Per-triangle setup stage directly upstream of `fragment_generator`. It accepts three screen-space vertices over a valid/ready handshake and computes the three edge-function coefficient sets (a, b, c), the screen-clamped bounding box and the barycentric denominator. Degenerate, off-screen and (optionally) back-facing triangles are culled here. Surviving triangles are presented with their depths and coefficients to the fragment generator's `valid_in` interface.

---
 rtl/triangle_setup.sv | 251 +++++++++++++++++++++++++
 tb/tb_triangle_setup.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_setup.sv
// triangle_setup: turns three screen-space vertices into edge coefficients, a clamped
// bounding box and |2*area|, culling degenerate, off-screen and optionally back-facing triangles.
module triangle_setup #(
    parameter int INPUT_COORD_W = 32,
    parameter int COEFF_W       = 16,
    parameter int DEPTH_W       = 32,
    parameter int SCREEN_W      = 16,
    parameter int SCREEN_H      = 16,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INPUT_COORD_W-1:0] x0_in,
    input  logic [INPUT_COORD_W-1:0] y0_in,
    input  logic [INPUT_COORD_W-1:0] z0_in,
    input  logic [INPUT_COORD_W-1:0] x1_in,
    input  logic [INPUT_COORD_W-1:0] y1_in,
    input  logic [INPUT_COORD_W-1:0] z1_in,
    input  logic [INPUT_COORD_W-1:0] x2_in,
    input  logic [INPUT_COORD_W-1:0] y2_in,
    input  logic [INPUT_COORD_W-1:0] z2_in,
    input  logic                     cull_enable,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INPUT_COORD_W-1:0] x0_out,
    output logic [INPUT_COORD_W-1:0] y0_out,
    output logic [INPUT_COORD_W-1:0] z0_out,
    output logic [INPUT_COORD_W-1:0] x1_out,
    output logic [INPUT_COORD_W-1:0] y1_out,
    output logic [INPUT_COORD_W-1:0] z1_out,
    output logic [INPUT_COORD_W-1:0] x2_out,
    output logic [INPUT_COORD_W-1:0] y2_out,
    output logic [INPUT_COORD_W-1:0] z2_out,
    output logic [COEFF_W-1:0]       a0,
    output logic [COEFF_W-1:0]       a1,
    output logic [COEFF_W-1:0]       a2,
    output logic [COEFF_W-1:0]       b0,
    output logic [COEFF_W-1:0]       b1,
    output logic [COEFF_W-1:0]       b2,
    output logic [COEFF_W-1:0]       c0,
    output logic [COEFF_W-1:0]       c1,
    output logic [COEFF_W-1:0]       c2,
    output logic [INPUT_COORD_W-1:0] min_x,
    output logic [INPUT_COORD_W-1:0] min_y,
    output logic [INPUT_COORD_W-1:0] max_x,
    output logic [INPUT_COORD_W-1:0] max_y,
    output logic [2*DEPTH_W-1:0]     denom,
    output logic                     culled,
    output logic                     busy,
    output logic [CNT_W-1:0]         tri_accepted,
    output logic [CNT_W-1:0]         tri_culled
);
    localparam int W  = INPUT_COORD_W;
    localparam int DW = W + 1;
    localparam int PW = 2 * W + 1;
    localparam int NW = 2 * DEPTH_W;

    typedef enum logic [2:0] {IDLE, EDGE, AREA, FIN, OUT} state_t;

    state_t                    state_q, state_d;
    logic [2:0][W-1:0]         x_q, x_d, y_q, y_d, z_q, z_d;
    logic                      cull_en_q, cull_en_d;
    logic [2:0][COEFF_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [2:0][COEFF_W-1:0]   xl, yl;
    logic signed [DW-1:0]      dx1_q, dx1_d, dy1_q, dy1_d, dx2_q, dx2_d, dy2_q, dy2_d;
    logic signed [PW-1:0]      area_q, area_d;
    logic [W-1:0]              min_x_q, min_x_d, min_y_q, min_y_d, max_x_q, max_x_d, max_y_q, max_y_d;
    logic [NW-1:0]             denom_q, denom_d;
    logic                      culled_q, culled_d;
    logic [CNT_W-1:0]          acc_q, acc_d, cul_q, cul_d;
    logic                      drop, flip;

    function automatic logic [W-1:0] min3(input logic [2:0][W-1:0] v);
        logic [W-1:0] m;
        m = v[0] < v[1] ? v[0] : v[1];
        return m < v[2] ? m : v[2];
    endfunction

    function automatic logic [W-1:0] max3(input logic [2:0][W-1:0] v);
        logic [W-1:0] m;
        m = v[0] > v[1] ? v[0] : v[1];
        return m > v[2] ? m : v[2];
    endfunction

    // Coefficients keep only COEFF_W bits, so low-bit arithmetic gives the same truncated result
    for (genvar i = 0; i < 3; i++) begin : g_low
        assign xl[i] = x_q[i][COEFF_W-1:0];
        assign yl[i] = y_q[i][COEFF_W-1:0];
    end

    assign drop = area_q == '0 || min_x_q >= W'(SCREEN_W) || min_y_q >= W'(SCREEN_H) ||
                  (area_q < 0 && cull_en_q);
    assign flip = area_q < 0;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        cull_en_d = cull_en_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        dx1_d     = dx1_q;
        dy1_d     = dy1_q;
        dx2_d     = dx2_q;
        dy2_d     = dy2_q;
        area_d    = area_q;
        min_x_d   = min_x_q;
        min_y_d   = min_y_q;
        max_x_d   = max_x_q;
        max_y_d   = max_y_q;
        denom_d   = denom_q;
        culled_d  = 1'b0;
        acc_d     = acc_q;
        cul_d     = cul_q;
        case (state_q)
            IDLE: if (in_valid) begin
                x_d       = {x2_in, x1_in, x0_in};
                y_d       = {y2_in, y1_in, y0_in};
                z_d       = {z2_in, z1_in, z0_in};
                cull_en_d = cull_enable;
                acc_d     = acc_q + CNT_W'(acc_q != '1);
                state_d   = EDGE;
            end
            EDGE: begin
                a_d[0]  = yl[1] - yl[2];
                b_d[0]  = xl[2] - xl[1];
                a_d[1]  = yl[2] - yl[0];
                b_d[1]  = xl[0] - xl[2];
                a_d[2]  = yl[0] - yl[1];
                b_d[2]  = xl[1] - xl[0];
                dx1_d   = $signed({1'b0, x_q[1]}) - $signed({1'b0, x_q[0]});
                dy1_d   = $signed({1'b0, y_q[1]}) - $signed({1'b0, y_q[0]});
                dx2_d   = $signed({1'b0, x_q[2]}) - $signed({1'b0, x_q[0]});
                dy2_d   = $signed({1'b0, y_q[2]}) - $signed({1'b0, y_q[0]});
                state_d = AREA;
            end
            AREA: begin
                c_d[0]  = xl[1] * yl[2] - xl[2] * yl[1];
                c_d[1]  = xl[2] * yl[0] - xl[0] * yl[2];
                c_d[2]  = xl[0] * yl[1] - xl[1] * yl[0];
                area_d  = PW'(dx1_q) * PW'(dy2_q) - PW'(dx2_q) * PW'(dy1_q);
                min_x_d = min3(x_q);
                min_y_d = min3(y_q);
                max_x_d = max3(x_q);
                max_y_d = max3(y_q);
                state_d = FIN;
            end
            FIN: if (drop) begin
                culled_d = 1'b1;
                cul_d    = cul_q + CNT_W'(cul_q != '1);
                state_d  = IDLE;
            end else begin
                // Clockwise survivors are flipped so every edge is positive inside
                for (int i = 0; i < 3; i++) begin
                    a_d[i] = flip ? -a_q[i] : a_q[i];
                    b_d[i] = flip ? -b_q[i] : b_q[i];
                    c_d[i] = flip ? -c_q[i] : c_q[i];
                end
                denom_d = flip ? NW'(-area_q) : NW'(area_q);
                max_x_d = max_x_q > W'(SCREEN_W - 1) ? W'(SCREEN_W - 1) : max_x_q;
                max_y_d = max_y_q > W'(SCREEN_H - 1) ? W'(SCREEN_H - 1) : max_y_q;
                state_d = OUT;
            end
            OUT: state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            cull_en_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            dx1_q     <= '0;
            dy1_q     <= '0;
            dx2_q     <= '0;
            dy2_q     <= '0;
            area_q    <= '0;
            min_x_q   <= '0;
            min_y_q   <= '0;
            max_x_q   <= '0;
            max_y_q   <= '0;
            denom_q   <= '0;
            culled_q  <= 1'b0;
            acc_q     <= '0;
            cul_q     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            cull_en_q <= cull_en_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            dx1_q     <= dx1_d;
            dy1_q     <= dy1_d;
            dx2_q     <= dx2_d;
            dy2_q     <= dy2_d;
            area_q    <= area_d;
            min_x_q   <= min_x_d;
            min_y_q   <= min_y_d;
            max_x_q   <= max_x_d;
            max_y_q   <= max_y_d;
            denom_q   <= denom_d;
            culled_q  <= culled_d;
            acc_q     <= acc_d;
            cul_q     <= cul_d;
        end
    end

    assign in_ready     = state_q == IDLE;
    assign out_valid    = state_q == OUT;
    assign busy         = state_q != IDLE;
    assign culled       = culled_q;
    assign tri_accepted = acc_q;
    assign tri_culled   = cul_q;
    assign x0_out       = x_q[0];
    assign y0_out       = y_q[0];
    assign z0_out       = z_q[0];
    assign x1_out       = x_q[1];
    assign y1_out       = y_q[1];
    assign z1_out       = z_q[1];
    assign x2_out       = x_q[2];
    assign y2_out       = y_q[2];
    assign z2_out       = z_q[2];
    assign a0           = a_q[0];
    assign a1           = a_q[1];
    assign a2           = a_q[2];
    assign b0           = b_q[0];
    assign b1           = b_q[1];
    assign b2           = b_q[2];
    assign c0           = c_q[0];
    assign c1           = c_q[1];
    assign c2           = c_q[2];
    assign min_x        = min_x_q;
    assign min_y        = min_y_q;
    assign max_x        = max_x_q;
    assign max_y        = max_y_q;
    assign denom        = denom_q;

endmodule

// File: tb/tb_triangle_setup.sv
// tb_triangle_setup: directed vector table plus backpressure and mid-flight reset sequences.
module tb_triangle_setup;
    localparam int W = 32;

    logic clk = 0, rst = 1, in_valid = 0, cull_enable = 0, out_ready = 1;
    logic [W-1:0] x0_in = 0, y0_in = 0, z0_in = 0, x1_in = 0, y1_in = 0, z1_in = 0;
    logic [W-1:0] x2_in = 0, y2_in = 0, z2_in = 0;
    logic in_ready, out_valid, culled, busy;
    logic [W-1:0] x0_out, y0_out, z0_out, x1_out, y1_out, z1_out, x2_out, y2_out, z2_out;
    logic [15:0] a0, a1, a2, b0, b1, b2, c0, c1, c2;
    logic [W-1:0] min_x, min_y, max_x, max_y;
    logic [63:0] denom;
    logic [15:0] tri_accepted, tri_culled;

    int n_chk = 0, n_fail = 0;
    int exp_acc = 0, exp_cul = 0;
    int lat;

    triangle_setup #(
        .INPUT_COORD_W(32), .COEFF_W(16), .DEPTH_W(32),
        .SCREEN_W(16), .SCREEN_H(16), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x0_in(x0_in), .y0_in(y0_in), .z0_in(z0_in),
        .x1_in(x1_in), .y1_in(y1_in), .z1_in(z1_in),
        .x2_in(x2_in), .y2_in(y2_in), .z2_in(z2_in),
        .cull_enable(cull_enable), .out_valid(out_valid), .out_ready(out_ready),
        .x0_out(x0_out), .y0_out(y0_out), .z0_out(z0_out),
        .x1_out(x1_out), .y1_out(y1_out), .z1_out(z1_out),
        .x2_out(x2_out), .y2_out(y2_out), .z2_out(z2_out),
        .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2), .c0(c0), .c1(c1), .c2(c2),
        .min_x(min_x), .min_y(min_y), .max_x(max_x), .max_y(max_y),
        .denom(denom), .culled(culled), .busy(busy),
        .tri_accepted(tri_accepted), .tri_culled(tri_culled)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x0, y0, x1, y1, x2, y2;
        bit ce, cull;
        int a0, b0, c0, a1, b1, c1, a2, b2, c2;
        int mnx, mny, mxx, mxy;
        longint den;
    } vec_t;

    vec_t tv [10];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        x0_in = t.x0; y0_in = t.y0; z0_in = 111;
        x1_in = t.x1; y1_in = t.y1; z1_in = 222;
        x2_in = t.x2; y2_in = t.y2; z2_in = 333;
        cull_enable = t.ce;
        in_valid = 1;
    endtask

    // called at the first falling edge after the accepting edge; counts that cycle as 1
    task automatic wait_done(output int l);
        l = 1;
        while (!(out_valid || culled) && l < 12) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic check_outputs(input string p, input vec_t t);
        logic [287:0] got, exp;
        chk({p, " a0"}, longint'($signed(a0)), t.a0);
        chk({p, " b0"}, longint'($signed(b0)), t.b0);
        chk({p, " c0"}, longint'($signed(c0)), t.c0);
        chk({p, " a1"}, longint'($signed(a1)), t.a1);
        chk({p, " b1"}, longint'($signed(b1)), t.b1);
        chk({p, " c1"}, longint'($signed(c1)), t.c1);
        chk({p, " a2"}, longint'($signed(a2)), t.a2);
        chk({p, " b2"}, longint'($signed(b2)), t.b2);
        chk({p, " c2"}, longint'($signed(c2)), t.c2);
        chk({p, " min_x"}, longint'(min_x), t.mnx);
        chk({p, " min_y"}, longint'(min_y), t.mny);
        chk({p, " max_x"}, longint'(max_x), t.mxx);
        chk({p, " max_y"}, longint'(max_y), t.mxy);
        chk({p, " denom"}, longint'(denom), t.den);
        got = {x0_out, y0_out, z0_out, x1_out, y1_out, z1_out, x2_out, y2_out, z2_out};
        exp = {t.x0, t.y0, 32'd111, t.x1, t.y1, 32'd222, t.x2, t.y2, 32'd333};
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s vertices: got %h expected %h", p, got, exp);
        end
    endtask

    task automatic run_vec(input string p, input vec_t t);
        int l;
        drive(t);
        out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        exp_acc++;
        if (t.cull) exp_cul++;
        wait_done(l);
        chk({p, " latency"}, l, 4);
        chk({p, " culled"}, culled, t.cull);
        chk({p, " out_valid"}, out_valid, !t.cull);
        if (!t.cull) check_outputs(p, t);
        chk({p, " tri_accepted"}, tri_accepted, exp_acc);
        chk({p, " tri_culled"}, tri_culled, exp_cul);
        @(negedge clk);
        chk({p, " in_ready after"}, in_ready, 1);
        chk({p, " culled one cycle"}, culled, 0);
        chk({p, " out_valid after"}, out_valid, 0);
    endtask

    task automatic expect_quiet(input string p);
        int seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen |= int'(culled) | int'(out_valid) | int'(busy);
        end
        chk({p, " no pulse after reset"}, seen, 0);
    endtask

    initial begin
        tv[0] = '{0,0,8,0,0,8,    1,0, -8,-8,64,    8,0,0,   0,8,0,     0,0,8,8,    64};
        tv[1] = '{0,0,0,8,8,0,    1,1, 0,0,0,       0,0,0,   0,0,0,     0,0,0,0,    0};
        tv[2] = '{0,0,0,8,8,0,    0,0, -8,-8,64,    0,8,0,   8,0,0,     0,0,8,8,    64};
        tv[3] = '{0,0,4,4,8,8,    0,1, 0,0,0,       0,0,0,   0,0,0,     0,0,0,0,    0};
        tv[4] = '{20,1,25,1,20,5, 1,1, 0,0,0,       0,0,0,   0,0,0,     0,0,0,0,    0};
        tv[5] = '{2,2,30,2,2,9,   1,0, -7,-28,266,  7,0,-14, 0,28,-56,  2,2,15,9,   196};
        tv[6] = '{1,20,5,20,1,25, 0,1, 0,0,0,       0,0,0,   0,0,0,     0,0,0,0,    0};
        tv[7] = '{3,1,3,20,10,4,  0,0, -16,-7,188,  -3,7,2,  19,0,-57,  3,1,10,15,  133};
        tv[8] = '{15,0,20,0,15,3, 1,0, -3,-5,60,    3,0,-45, 0,5,0,     15,0,15,3,  15};
        tv[9] = '{16,0,20,0,16,3, 1,1, 0,0,0,       0,0,0,   0,0,0,     0,0,0,0,    0};

        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset culled", culled, 0);
        chk("reset tri_accepted", tri_accepted, 0);
        chk("reset denom", longint'(denom), 0);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec($sformatf("v%0d", i), tv[i]);

        // backpressure: hold the result for three cycles with a competing triangle offered
        out_ready = 0;
        drive(tv[0]);
        @(negedge clk);
        in_valid = 0;
        exp_acc++;
        wait_done(lat);
        chk("bp latency", lat, 4);
        drive(tv[5]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp out_valid held", out_valid, 1);
            chk("bp in_ready low", in_ready, 0);
            chk("bp a0 stable", longint'($signed(a0)), -8);
            chk("bp c0 stable", longint'($signed(c0)), 64);
            chk("bp denom stable", longint'(denom), 64);
            chk("bp x1_out stable", longint'(x1_out), 8);
            chk("bp tri_accepted", tri_accepted, exp_acc);
        end
        out_ready = 1;
        @(negedge clk);
        chk("bp release out_valid", out_valid, 0);
        chk("bp release in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        exp_acc++;
        chk("bp next accepted busy", busy, 1);
        chk("bp next tri_accepted", tri_accepted, exp_acc);
        wait_done(lat);
        chk("bp next latency", lat, 4);
        chk("bp next out_valid", out_valid, 1);
        check_outputs("bp next", tv[5]);
        @(negedge clk);

        // asynchronous reset while in AREA
        drive(tv[0]);
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        chk("area busy before reset", busy, 1);
        #1 rst = 1;
        #1;
        chk("area rst busy", busy, 0);
        chk("area rst in_ready", in_ready, 1);
        chk("area rst a0", longint'(a0), 0);
        chk("area rst tri_accepted", tri_accepted, 0);
        chk("area rst tri_culled", tri_culled, 0);
        exp_acc = 0;
        exp_cul = 0;
        @(negedge clk);
        rst = 0;
        expect_quiet("area");
        run_vec("after area rst", tv[0]);

        // asynchronous reset while a result is waiting in OUT
        out_ready = 0;
        drive(tv[5]);
        @(negedge clk);
        in_valid = 0;
        wait_done(lat);
        chk("out state reached", out_valid, 1);
        #1 rst = 1;
        #1;
        chk("out rst out_valid", out_valid, 0);
        chk("out rst in_ready", in_ready, 1);
        chk("out rst denom", longint'(denom), 0);
        chk("out rst max_x", longint'(max_x), 0);
        chk("out rst x1_out", longint'(x1_out), 0);
        chk("out rst tri_accepted", tri_accepted, 0);
        exp_acc = 0;
        exp_cul = 0;
        @(negedge clk);
        rst = 0;
        out_ready = 1;
        expect_quiet("out");
        run_vec("after out rst", tv[8]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
